// File: rtl/inst_pkg.sv
// Shared opcodes, error codes and the FIFO entry layout for the instruction encoder.
package inst_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_RANGE = 2'd1,
    ERR_ALIGN = 2'd2,
    ERR_OPC   = 2'd3
  } err_e;

  typedef struct packed {
    err_e        err;
    logic [31:0] inst;
  } entry_t;

  // True when v[31:msb] are all equal, i.e. v sign-extends from bit msb.
  function automatic logic sext_fits(input logic [31:0] v, input int unsigned msb);
    logic [31:0] ones;
    logic [31:0] top;
    ones = '1;
    top  = v >> msb;
    return (top == '0) || (top == (ones >> msb));
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Generic synchronous FIFO with occupancy count; head data reads as zero when empty.
module enc_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 34
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop never frees room for a same-cycle push: push is gated on full alone.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/inst_encoder.sv
// Encodes instruction fields into a 32-bit word with range/alignment checks,
// queued in an output FIFO with saturating ok/error counters.
module inst_encoder
  import inst_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [1:0]       out_err,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err
);

  entry_t                  enc;
  entry_t                  head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    push;
  logic                    pop;
  logic [CNT_W-1:0]        cnt_ok_q, cnt_ok_d;
  logic [CNT_W-1:0]        cnt_err_q, cnt_err_d;
  logic                    is_shift;
  logic                    bad_range;
  logic                    bad_align;
  logic [31:0]             i;

  assign i        = in_imm;
  assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  // Error priority is resolved last: unknown opcode > misaligned > range.
  always_comb begin
    enc.inst  = '0;
    enc.err   = ERR_NONE;
    bad_range = 1'b0;
    bad_align = 1'b0;
    case (in_opcode)
      OP_R: begin
        enc.inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      OP_LOAD, OP_JALR: begin
        enc.inst  = {i[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        bad_range = !sext_fits(i, 11);
      end
      OP_IMM: begin
        if (is_shift) begin
          enc.inst  = {in_funct7, i[4:0], in_rs1, in_funct3, in_rd, in_opcode};
          bad_range = (i[31:5] != '0);
        end else begin
          enc.inst  = {i[11:0], in_rs1, in_funct3, in_rd, in_opcode};
          bad_range = !sext_fits(i, 11);
        end
      end
      OP_STORE: begin
        enc.inst  = {i[11:5], in_rs2, in_rs1, in_funct3, i[4:0], in_opcode};
        bad_range = !sext_fits(i, 11);
      end
      OP_BRANCH: begin
        enc.inst  = {i[12], i[10:5], in_rs2, in_rs1, in_funct3, i[4:1], i[11], in_opcode};
        bad_align = i[0];
        bad_range = !sext_fits(i, 12);
      end
      OP_LUI, OP_AUIPC: begin
        enc.inst  = {i[31:12], in_rd, in_opcode};
        bad_align = (i[11:0] != '0);
      end
      OP_JAL: begin
        enc.inst  = {i[20], i[10:1], i[11], i[19:12], in_rd, in_opcode};
        bad_align = i[0];
        bad_range = !sext_fits(i, 20);
      end
      default: begin
        enc.inst = '0;
        enc.err  = ERR_OPC;
      end
    endcase
    if (enc.err != ERR_OPC) begin
      if (bad_align) begin
        enc.err = ERR_ALIGN;
      end else if (bad_range) begin
        enc.err = ERR_RANGE;
      end
    end
  end

  assign in_ready  = rst_n && !fifo_full;
  assign push      = in_valid && in_ready;
  assign pop       = out_ready && (fifo_count != '0);
  assign out_valid = !fifo_empty;
  assign out_inst  = head.inst;
  assign out_err   = head.err;

  enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (enc),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    cnt_ok_d  = cnt_ok_q;
    cnt_err_d = cnt_err_q;
    if (push) begin
      if (enc.err == ERR_NONE) begin
        if (cnt_ok_q != '1) cnt_ok_d = cnt_ok_q + CNT_W'(1);
      end else begin
        if (cnt_err_q != '1) cnt_err_d = cnt_err_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_ok_q  <= '0;
      cnt_err_q <= '0;
    end else begin
      cnt_ok_q  <= cnt_ok_d;
      cnt_err_q <= cnt_err_d;
    end
  end

  assign cnt_ok  = cnt_ok_q;
  assign cnt_err = cnt_err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized and directed bench for inst_encoder against an arithmetic reference model.
module tb_inst_encoder;

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       in_opcode;
  logic [4:0]       in_rd, in_rs1, in_rs2;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic [1:0]       out_err;
  logic [CNT_W-1:0] cnt_ok, cnt_err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [33:0] model_q[$];
  int unsigned m_ok, m_err;
  logic        dir_chk = 1'b0;
  logic [31:0] dir_inst;
  logic [1:0]  dir_err;
  logic        dir_use_inst;

  inst_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err),
    .cnt_ok(cnt_ok), .cnt_err(cnt_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoding returns {err, inst}; ranges are expressed as signed intervals.
  function automatic logic [33:0] ref_enc(input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    logic [31:0] inst;
    logic [1:0]  err;
    int          s;
    s    = $signed(imm);
    err  = 2'd0;
    inst = 32'(rs1) * 32'h8000 + 32'(f3) * 32'h1000 + 32'(op);
    case (op)
      7'h33: inst = inst + 32'(f7) * (1 << 25) + 32'(rs2) * (1 << 20) + 32'(rd) * 128;
      7'h03, 7'h67: begin
        inst = inst + (imm % 4096) * (1 << 20) + 32'(rd) * 128;
        if (s < -2048 || s > 2047) err = 2'd1;
      end
      7'h13: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          inst = inst + 32'(f7) * (1 << 25) + (imm % 32) * (1 << 20) + 32'(rd) * 128;
          if (imm > 31) err = 2'd1;
        end else begin
          inst = inst + (imm % 4096) * (1 << 20) + 32'(rd) * 128;
          if (s < -2048 || s > 2047) err = 2'd1;
        end
      end
      7'h23: begin
        inst = inst + ((imm / 32) % 128) * (1 << 25) + 32'(rs2) * (1 << 20) + (imm % 32) * 128;
        if (s < -2048 || s > 2047) err = 2'd1;
      end
      7'h63: begin
        inst = inst + ((imm / 4096) % 2) * (1 << 31) + ((imm / 32) % 64) * (1 << 25)
             + 32'(rs2) * (1 << 20) + ((imm / 2) % 16) * 256 + ((imm / 2048) % 2) * 128;
        if (imm % 2 != 0) err = 2'd2;
        else if (s < -4096 || s > 4095) err = 2'd1;
      end
      7'h37, 7'h17: begin
        inst = imm - (imm % 4096) + 32'(rd) * 128 + 32'(op);
        if (imm % 4096 != 0) err = 2'd2;
      end
      7'h6f: begin
        inst = ((imm / (1 << 20)) % 2) * (1 << 31) + ((imm / 2) % 1024) * (1 << 21)
             + ((imm / 2048) % 2) * (1 << 20) + ((imm / 4096) % 256) * 4096
             + 32'(rd) * 128 + 32'(op);
        if (imm % 2 != 0) err = 2'd2;
        else if (s < -(1 << 20) || s > (1 << 20) - 1) err = 2'd1;
      end
      default: begin
        inst = 32'd0;
        err  = 2'd3;
      end
    endcase
    return {err, inst};
  endfunction

  task automatic cycle();
    logic        do_push, do_pop;
    logic [33:0] e;
    @(negedge clk);
    if (rst_n) begin
      check("in_ready", 34'(in_ready), 34'(model_q.size() < DEPTH));
      check("out_valid", 34'(out_valid), 34'(model_q.size() != 0));
      if (model_q.size() != 0) begin
        check("out_inst", 34'(out_inst), 34'(model_q[0][31:0]));
        check("out_err", 34'(out_err), 34'(model_q[0][33:32]));
      end
      check("cnt_ok", 34'(cnt_ok), 34'(m_ok));
      check("cnt_err", 34'(cnt_err), 34'(m_err));
      if (dir_chk) begin
        if (dir_use_inst) check("dir_inst", 34'(out_inst), 34'(dir_inst));
        check("dir_err", 34'(out_err), 34'(dir_err));
        dir_chk = 1'b0;
      end
    end else begin
      check("in_ready_rst", 34'(in_ready), 34'd0);
    end
    do_push = rst_n && in_valid && (model_q.size() < DEPTH);
    do_pop  = rst_n && out_ready && (model_q.size() != 0);
    e = ref_enc(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
    @(posedge clk);
    if (!rst_n) begin
      model_q.delete();
      m_ok  = 0;
      m_err = 0;
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        model_q.push_back(e);
        if (e[33:32] == 2'd0) begin
          if (m_ok < CNT_MAX) m_ok++;
        end else if (m_err < CNT_MAX) m_err++;
      end
    end
    #1;
  endtask

  task automatic set_fields(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic send_dir(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
      input logic use_inst, input logic [31:0] exp_inst, input logic [1:0] exp_err);
    out_ready = 1'b1;
    set_fields(op, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    cycle();
    in_valid     = 1'b0;
    dir_use_inst = use_inst;
    dir_inst     = exp_inst;
    dir_err      = exp_err;
    dir_chk      = 1'b1;
    cycle();
  endtask

  initial begin
    logic [6:0] ops [12];
    ops = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h7f, 7'h13, 7'h00};
    m_ok = 0; m_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_fields('0, '0, '0, '0, '0, '0, '0);
    #1;
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();
    check("rst_out_inst", 34'(out_inst), 34'd0);

    send_dir(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF1_0093, 2'd0);
    check("cnt_ok_first", 34'(cnt_ok), 34'd1);
    send_dir(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'd0, 2'd1);
    send_dir(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1'b1, 32'h0020_8463, 2'd0);
    send_dir(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7, 1'b0, 32'd0, 2'd2);
    send_dir(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4096, 1'b0, 32'd0, 2'd1);
    send_dir(7'h6f, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1, 32'h0010_00EF, 2'd0);
    send_dir(7'h6f, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 1'b0, 32'd0, 2'd1);
    send_dir(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1, 32'h1234_52B7, 2'd0);
    send_dir(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 1'b0, 32'd0, 2'd2);
    send_dir(7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd31, 1'b1, 32'h01F0_9093, 2'd0);
    send_dir(7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd32, 1'b0, 32'd0, 2'd1);
    send_dir(7'h13, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 32'd3, 1'b1, 32'h4030_D093, 2'd0);
    send_dir(7'h7f, 5'd3, 5'd4, 5'd5, 3'd2, 7'd1, 32'd0, 1'b1, 32'd0, 2'd3);

    // Backpressure: three bundles into a two-entry FIFO with the consumer stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_fields(7'h33, 5'(k + 1), 5'(k + 2), 5'(k + 3), 3'(k), 7'(k), 32'd0);
      cycle();
    end
    check("bp_in_ready", 34'(in_ready), 34'd0);
    out_ready = 1'b1;
    cycle(); cycle();
    in_valid = 1'b0;
    cycle(); cycle(); cycle();

    // Reset with entries queued.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_fields(7'h33, 5'd9, 5'd8, 5'd7, 3'd6, 7'd5, 32'd0);
    cycle(); cycle();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    check("rst_out_valid", 34'(out_valid), 34'd0);
    check("rst_cnt_ok", 34'(cnt_ok), 34'd0);
    check("rst_cnt_err", 34'(cnt_err), 34'd0);
    check("rst_out_inst2", 34'(out_inst), 34'd0);

    // Saturation of the ok counter.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 17; k++) begin
      set_fields(7'h33, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), $urandom);
      cycle();
    end
    in_valid = 1'b0;
    cycle(); cycle();
    check("cnt_ok_sat", 34'(cnt_ok), 34'(CNT_MAX));

    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 400; k++) begin
      logic [31:0] imm;
      case ($urandom_range(0, 3))
        0:       imm = $urandom;
        1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2:       imm = $urandom & 32'hFFFF_F000;
        default: imm = 32'($urandom_range(0, 40));
      endcase
      set_fields(ops[$urandom_range(0, 11)], 5'($urandom), 5'($urandom), 5'($urandom),
                 3'($urandom), 7'($urandom), imm);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < DEPTH + 2; k++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Inverse of the core's immediate decoder. It accepts instruction fields (opcode, registers, funct bits, 32-bit signed immediate), scatters the immediate into its format-specific bit positions, and checks range and alignment. It queues the resulting 32-bit instruction word in a small output FIFO. Used by the debug program-buffer writer and the self-test stimulus generator, with valid/ready handshakes on both sides.

Parameters:
DEPTH, 2, output FIFO entries (power of two, >=2)
CNT_W, 16, width of saturating ok/error counters

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept bundle
in_opcode  in  7  major opcode
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_funct3  in  3  funct3
in_funct7  in  7  funct7 (R-type, shift-immediates)
in_imm  in  32  signed immediate, byte offset for B/J
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer takes head
out_inst  out  32  encoded instruction at head
out_err  out  2  head error code: 0 ok, 1 range, 2 misaligned, 3 unknown opcode
cnt_ok  out  CNT_W  pushed entries with err=0, saturating
cnt_err  out  CNT_W  pushed entries with err!=0, saturating

Behaviour:
- Reset (rst_n low at clk edge): FIFO emptied, pointers 0. out_valid=0, out_inst=0, out_err=0, cnt_ok=cnt_err=0. in_ready=0 while rst_n low. Reset mid-stream discards all queued entries.
- Accept when in_valid & in_ready. in_ready = !full. There is no push-while-full bypass, even if a pop happens in the same cycle.
- Encoding is combinational on the input fields and is written into the FIFO on accept. out_valid rises the cycle after the first accept into an empty FIFO (latency 1). There is no combinational path from in_* to out_*.
- Pop on out_valid & out_ready. Simultaneous push and pop when not full keeps the count unchanged. Strict FIFO order. Pointers wrap modulo DEPTH.
- Format encodings (i = in_imm):
  - R 0110011: {funct7, rs2, rs1, funct3, rd, op}. Imm ignored, never errors.
  - I 0000011/1100111/0010011: {i[11:0], rs1, funct3, rd, op}. Range error unless i[31:11] are all equal.
  - Shift immediates (op 0010011, funct3 001 or 101): {funct7, i[4:0], rs1, funct3, rd, op}. Range error unless i[31:5]==0.
  - S 0100011: {i[11:5], rs2, rs1, funct3, i[4:0], op}. Range check as for I.
  - B 1100011: {i[12], i[10:5], rs2, rs1, funct3, i[4:1], i[11], op}. Misaligned if i[0]=1. Range error unless i[31:12] are all equal.
  - U 0110111/0010111: {i[31:12], rd, op}. Misaligned if i[11:0]!=0.
  - J 1101111: {i[20], i[10:1], i[11], i[19:12], rd, op}. Misaligned if i[0]=1. Range error unless i[31:20] are all equal.
  - Any other opcode: err=3, inst=0.
- Error priority: unknown > misaligned > range.
- Erroneous entries are still pushed, with inst holding the truncated encoding (0 for unknown).
- Counters update on push only. They hold at all-ones rather than wrapping.

Decomposition:
- Shared package inst_pkg holds:
  - opcode localparams (OP_R, OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL)
  - the 2-bit error enum (ERR_NONE, ERR_RANGE, ERR_ALIGN, ERR_OPC)
  - a typedef for the {err, inst} FIFO entry
- Sub-module enc_fifo: generic DEPTH-entry synchronous FIFO with count, full and empty.
- Encoder and error logic stay in inst_encoder.

Test Plan:
- Immediate formats: addi x1,x2,-1 (op 0010011, rd1, rs1 2, f3 0, imm 0xFFFFFFFF), out_ready=1 -> next cycle out_inst=0xFFF10093, err=0, cnt_ok=1. Then imm=2048 -> err=1.
- Branch: beq x1,x2,+8 (op 1100011, rs1 1, rs2 2, imm 8) -> 0x00208463, err=0. imm=7 -> err=2. imm=4096 -> err=1.
- Jump and upper-immediate:
  - jal x1,2048 -> 0x001000EF.
  - imm 0x00100000 -> err=1.
  - lui x5,0x12345000 -> 0x123452B7.
  - lui imm 0x12345001 -> err=2.
- Shifts and unknown opcode: slli x1,x1,31 ok. slli with imm 32 -> err=1. srai x1,x1,3 (funct7 0100000) -> 0x4030D093. op 0x7F -> err=3, inst=0, cnt_err increments.
- Backpressure: out_ready=0, DEPTH=2, three back-to-back in_valid pulses -> in_ready low after 2 accepts, third held. Release out_ready -> all three emerge in order, one per cycle.
- Reset and saturation:
  - Assert rst_n=0 with 2 queued -> next cycle out_valid=0, counters 0, in_ready=0 during reset.
  - With CNT_W=4, push 17 ok entries -> cnt_ok holds 15.
